shtp_spi_responder: RTL and testbench
=====================================

# shtp_spi_responder

Synthesizable, parametrised SHTP-over-SPI slave that emulates the BNO085 host interface for hardware-in-the-loop testing of the SPI master and SHTP parser. It sits between the FPGA's sensor-facing pins and an internal report generator. The block frames generator payloads into SHTP packets with per-channel sequence numbers, drives the PS0/WAKE and INT handshake, shifts data in SPI mode 3, and captures host commands for the generator to read.

## Interface
- NUM_CH, 6: number of SHTP channels; sequence counters kept per channel.
- TX_DEPTH, 64: TX packet buffer bytes, header included; maximum payload is TX_DEPTH-4.
- RX_DEPTH, 32: captured command bytes, header included.
- INT_DELAY, 50: clk cycles from event to INT assertion.
- clk  in  1  system clock; must be ≥8× SCLK.
- rst_n  in  1  asynchronous, active-low reset.
- ps0_wake_n  in  1  PS0/WAKE from host; a falling edge is a wake request.
- cs_n, sclk, mosi  in  1  SPI mode 3 from host, asynchronous to clk.
- miso  out  1  SPI data to host.
- int_n  out  1  data-ready, active low.
- load_valid  in  1  payload byte valid.
- load_ready  out  1  block accepts payload byte.
- load_byte  in  8  payload byte.
- load_last  in  1  marks the final payload byte of a packet.
- load_ch  in  $clog2(NUM_CH)  channel; sampled on the first byte of a packet.
- load_ovf  out  1  1-cycle pulse when a payload byte is dropped.
- cmd_valid  out  1  1-cycle pulse when a host command has been captured.
- cmd_ch  out  8  captured channel byte.
- cmd_len  out  16  captured header length field.
- cmd_trunc  out  1  fewer bytes clocked than cmd_len.
- cmd_rd_addr  in  $clog2(RX_DEPTH)  read address into the command buffer.
- cmd_rd_data  out  8  combinational read of the command buffer.

## Operation
- cs_n, sclk and ps0_wake_n pass through 2-flop synchronisers; edges are detected on the synchronised copies. mosi is sampled on a detected sclk rise.
- Packet load. Payload bytes are written to tx_buf[4+n]. On load_last:
  - header bytes are set to {len[7:0], len[15:8], ch, seq[ch]}, where len = n+4;
  - pending is set;
  - load_ready is high only while pending=0 and no CS transaction is active.
- Overflow. When n reaches TX_DEPTH-4, further bytes are dropped with a load_ovf pulse. load_last is still honoured, so the packet is sent truncated at TX_DEPTH bytes.
- INT. INT_DELAY cycles after pending rises, int_n goes low. The same applies after a ps0_wake_n falling edge, whether or not a packet is pending. int_n goes high on the first synchronised cs_n falling edge after assertion.
- TX shift. On every detected sclk fall while CS is low, miso is driven with the next MSB-first bit of tx_buf[ptr]. Past len bytes, or when pending=0, miso is 0.
- TX completion and retry.
  - At CS rise, if ≥len bytes were fully clocked: pending clears, seq[ch] increments mod 256, and int_n stays high.
  - Otherwise the packet stays pending, is resent from byte 0 with the same seq, and int_n re-asserts after INT_DELAY.
- RX capture. Bytes clocked in on mosi are stored at rx_buf[0..RX_DEPTH-1]; excess bytes are discarded. At CS rise, if ≥4 bytes were received, cmd_valid pulses for one cycle with:
  - cmd_len = {rx_buf[1], rx_buf[0]};
  - cmd_ch = rx_buf[2];
  - cmd_trunc = (bytes received < cmd_len).
- Partial last byte. A partial final byte (bit count ≠ 0) is discarded; bit counters reset at CS rise.
- Simultaneous events. A wake edge while INT is already pending does not restart the delay. A load_last on the same cycle as a CS fall is not possible, because load_ready is low during CS.

## Timing
- Reset values:
  - outputs: miso=0, int_n=1, load_ready=1, load_ovf=0, cmd_valid=0, cmd_ch=0, cmd_len=0, cmd_trunc=0;
  - internal state: all seq=0, pending=0, buffers undefined.
- An async reset mid-transaction aborts it: no cmd_valid, and any pending packet is lost.
- Synchroniser latency: 2 clk from a pin edge to its detection. miso updates 1 clk after a detected sclk fall, i.e. ≤3 clk after the pin edge, which sets the ≥8× ratio.
- cmd_valid fires 1 clk after the detected CS rise. TX completion is evaluated on the same cycle as the detected CS rise.
- After load_last is accepted, pending=1 and load_ready=0 on the next cycle.

## Test plan
- Load 14 payload bytes on ch 3, then clock 18 bytes → host reads 12 00 03 00 + payload and sees INT low INT_DELAY cycles after load_last, high after CS fall. Second packet on ch 3 → seq byte 01; a packet on ch 2 carries seq 00.
- Abort after 6 bytes (CS high) → packet resent in full with the same seq, int_n re-asserted, seq not incremented.
- Host sends 05 00 02 07 F9 → cmd_valid with cmd_ch=02, cmd_len=5, cmd_trunc=0, rd addr 4 = F9. Sending only 4 bytes with length 5 → cmd_trunc=1.
- Push TX_DEPTH payload bytes → exactly 4 load_ovf pulses; header length field = TX_DEPTH.
- ps0_wake_n falls with nothing pending → int_n low after INT_DELAY; host reads an all-zero packet (len 0).
- rst_n asserted during the 3rd byte → all outputs at reset values, next packet seq 00.

Source files
------------

// File: rtl/shtp_spi_responder_if.sv
// ----------------------------------------------------------------------------
// shtp_spi_responder_if
// Signal bundle between the SHTP-over-SPI responder and its surroundings.
//   SPI pins     : cs_n, sclk, mosi (to responder), miso (from responder)
//   Handshake    : ps0_wake_n (to responder), int_n (from responder)
//   Load port    : load_valid/load_byte/load_last/load_ch in, load_ready/load_ovf out
//   Command port : cmd_valid/cmd_ch/cmd_len/cmd_trunc/cmd_rd_data out, cmd_rd_addr in
// Modports: slave = responder side, master = host / generator side.
// ----------------------------------------------------------------------------
interface shtp_spi_responder_if #(
  parameter int NUM_CH   = 6,
  parameter int RX_DEPTH = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RA_W = $clog2(RX_DEPTH);

  logic            ps0_wake_n;
  logic            cs_n;
  logic            sclk;
  logic            mosi;
  logic            miso;
  logic            int_n;

  logic            load_valid;
  logic            load_ready;
  logic [7:0]      load_byte;
  logic            load_last;
  logic [CH_W-1:0] load_ch;
  logic            load_ovf;

  logic            cmd_valid;
  logic [7:0]      cmd_ch;
  logic [15:0]     cmd_len;
  logic            cmd_trunc;
  logic [RA_W-1:0] cmd_rd_addr;
  logic [7:0]      cmd_rd_data;

  modport slave (
    input  ps0_wake_n, cs_n, sclk, mosi,
    input  load_valid, load_byte, load_last, load_ch,
    input  cmd_rd_addr,
    output miso, int_n, load_ready, load_ovf,
    output cmd_valid, cmd_ch, cmd_len, cmd_trunc, cmd_rd_data
  );

  modport master (
    output ps0_wake_n, cs_n, sclk, mosi,
    output load_valid, load_byte, load_last, load_ch,
    output cmd_rd_addr,
    input  miso, int_n, load_ready, load_ovf,
    input  cmd_valid, cmd_ch, cmd_len, cmd_trunc, cmd_rd_data
  );
endinterface

// File: rtl/shtp_spi_responder.sv
// ----------------------------------------------------------------------------
// shtp_spi_responder
// SHTP-over-SPI slave emulating the BNO085 host interface. Frames payload
// bytes from a report generator into SHTP packets with per-channel sequence
// numbers, raises INT after a fixed delay, shifts the packet out in SPI
// mode 3 and captures the host's command bytes for the generator to read.
// Ports:
//   clk   : system clock (at least 8x SCLK)
//   rst_n : asynchronous active-low reset
//   bus   : shtp_spi_responder_if.slave (SPI pins, PS0/WAKE, INT, load
//           port, command port)
// ----------------------------------------------------------------------------
module shtp_spi_responder #(
  parameter int NUM_CH    = 6,
  parameter int TX_DEPTH  = 64,
  parameter int RX_DEPTH  = 32,
  parameter int INT_DELAY = 50
) (
  input  logic clk,
  input  logic rst_n,
  shtp_spi_responder_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TXW   = $clog2(TX_DEPTH);
  localparam int RA_W  = $clog2(RX_DEPTH);
  localparam int DLY_W = $clog2(INT_DELAY + 1);
  localparam logic [15:0]      PAY_MAX = 16'(TX_DEPTH - 4);
  localparam logic [15:0]      TX_LEN  = 16'(TX_DEPTH);
  localparam logic [15:0]      RX_MAX  = 16'(RX_DEPTH);
  localparam logic [DLY_W-1:0] DLY_LD  = DLY_W'(INT_DELAY - 1);

  // Pin synchronisers; bit [2] is the previous synchronised value for edges.
  logic [2:0] r_cs_s, r_sclk_s, r_wake_s;
  logic [1:0] r_mosi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s   <= '1;
      r_sclk_s <= '1;
      r_wake_s <= '1;
      r_mosi_s <= '0;
    end else begin
      r_cs_s   <= {r_cs_s[1:0],   bus.cs_n};
      r_sclk_s <= {r_sclk_s[1:0], bus.sclk};
      r_wake_s <= {r_wake_s[1:0], bus.ps0_wake_n};
      r_mosi_s <= {r_mosi_s[0],   bus.mosi};
    end
  end

  logic w_cs_act, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_wake_fall, w_mosi;
  assign w_cs_act    = ~r_cs_s[1];
  assign w_cs_fall   =  r_cs_s[2] & ~r_cs_s[1];
  assign w_cs_rise   = ~r_cs_s[2] &  r_cs_s[1];
  assign w_sclk_rise = w_cs_act & ~r_sclk_s[2] &  r_sclk_s[1];
  assign w_sclk_fall = w_cs_act &  r_sclk_s[2] & ~r_sclk_s[1];
  assign w_wake_fall =  r_wake_s[2] & ~r_wake_s[1];
  // mosi goes through the same two flops as sclk, so it lines up with the rise.
  assign w_mosi      = r_mosi_s[1];

  logic [7:0]      r_tx_buf [TX_DEPTH];
  logic [7:0]      r_rx_buf [RX_DEPTH];
  logic [6:0]      r_rx_sh;
  logic [7:0]      r_seq    [NUM_CH];
  logic            r_pending;
  logic [15:0]     r_len;
  logic [CH_W-1:0] r_tx_ch;
  logic [CH_W-1:0] r_ld_ch;
  logic [15:0]     r_ld_n;
  logic            r_ovf;
  logic [2:0]      r_bit;
  logic [15:0]     r_byte_cnt;
  logic            r_miso;
  logic            r_int_n;
  logic            r_int_arm;
  logic [DLY_W-1:0] r_int_cnt;
  logic            r_cmd_valid;
  logic [7:0]      r_cmd_ch;
  logic [15:0]     r_cmd_len;
  logic            r_cmd_trunc;

  // Load-port decode
  logic            w_ld_ready, w_ld_fire, w_ld_store, w_ld_end;
  logic [CH_W-1:0] w_ld_ch;
  logic [15:0]     w_ld_len;
  logic [TXW-1:0]  w_wr_idx;
  assign w_ld_ready = ~r_pending & ~w_cs_act;
  assign w_ld_fire  = bus.load_valid & w_ld_ready;
  assign w_ld_store = w_ld_fire & (r_ld_n < PAY_MAX);
  assign w_ld_end   = w_ld_fire & bus.load_last;
  // Channel is taken from the first byte of the packet.
  assign w_ld_ch    = (r_ld_n == 16'd0) ? bus.load_ch : r_ld_ch;
  // A dropped final byte means the buffer is full: length is the whole buffer.
  assign w_ld_len   = w_ld_store ? (r_ld_n + 16'd5) : TX_LEN;
  assign w_wr_idx   = r_ld_n[TXW-1:0] + TXW'(4);

  // SPI decode
  logic       w_rx_done, w_tx_short;
  logic [7:0] w_tx_byte, w_rx_byte;
  logic [15:0] w_rx_len;
  logic       w_int_trig;
  assign w_rx_done  = w_sclk_rise & (r_bit == 3'd7);
  assign w_rx_byte  = {r_rx_sh, w_mosi};
  assign w_tx_byte  = r_tx_buf[r_byte_cnt[TXW-1:0]];
  assign w_tx_short = r_byte_cnt < r_len;
  assign w_rx_len   = {r_rx_buf[1], r_rx_buf[0]};
  // A failed read (CS rose early) re-arms INT for the resend.
  assign w_int_trig = w_ld_end | w_wake_fall | (w_cs_rise & r_pending & w_tx_short);

  // Buffers and shift register carry no reset.
  always_ff @(posedge clk) begin
    if (w_ld_store) r_tx_buf[w_wr_idx] <= bus.load_byte;
    if (w_ld_end) begin
      r_tx_buf[0] <= w_ld_len[7:0];
      r_tx_buf[1] <= w_ld_len[15:8];
      r_tx_buf[2] <= {{(8-CH_W){1'b0}}, w_ld_ch};
      r_tx_buf[3] <= r_seq[w_ld_ch];
    end
    if (w_sclk_rise) r_rx_sh <= {r_rx_sh[5:0], w_mosi};
    if (w_rx_done && (r_byte_cnt < RX_MAX)) r_rx_buf[r_byte_cnt[RA_W-1:0]] <= w_rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_seq[i] <= '0;
      r_pending   <= 1'b0;
      r_len       <= '0;
      r_tx_ch     <= '0;
      r_ld_ch     <= '0;
      r_ld_n      <= '0;
      r_ovf       <= 1'b0;
      r_bit       <= '0;
      r_byte_cnt  <= '0;
      r_miso      <= 1'b0;
      r_int_n     <= 1'b1;
      r_int_arm   <= 1'b0;
      r_int_cnt   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_ch    <= '0;
      r_cmd_len   <= '0;
      r_cmd_trunc <= 1'b0;
    end else begin
      // Packet load
      r_ovf <= w_ld_fire & ~w_ld_store;
      if (w_ld_fire) begin
        if (r_ld_n == 16'd0) r_ld_ch <= bus.load_ch;
        if (bus.load_last) begin
          r_pending <= 1'b1;
          r_len     <= w_ld_len;
          r_tx_ch   <= w_ld_ch;
          r_ld_n    <= '0;
        end else if (w_ld_store) begin
          r_ld_n <= r_ld_n + 16'd1;
        end
      end

      // SPI bit/byte counters and MISO
      if (w_cs_fall || w_cs_rise) begin
        r_bit      <= '0;
        r_byte_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_bit <= r_bit + 3'd1;
        if (r_bit == 3'd7 && r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
      end
      if (w_cs_rise) r_miso <= 1'b0;
      else if (w_sclk_fall) r_miso <= (r_pending && w_tx_short) ? w_tx_byte[3'd7 - r_bit] : 1'b0;

      // Transaction end: TX completion and command capture
      r_cmd_valid <= 1'b0;
      if (w_cs_rise) begin
        if (r_pending && !w_tx_short) begin
          r_pending        <= 1'b0;
          r_seq[r_tx_ch]   <= r_seq[r_tx_ch] + 8'd1;
        end
        if (r_byte_cnt >= 16'd4) begin
          r_cmd_valid <= 1'b1;
          r_cmd_len   <= w_rx_len;
          r_cmd_ch    <= r_rx_buf[2];
          r_cmd_trunc <= r_byte_cnt < w_rx_len;
        end
      end

      // INT: delay counter; new triggers are ignored while counting or asserted
      if (w_cs_fall) r_int_n <= 1'b1;
      if (r_int_arm) begin
        if (r_int_cnt == '0) begin
          r_int_n   <= 1'b0;
          r_int_arm <= 1'b0;
        end else begin
          r_int_cnt <= r_int_cnt - 1'b1;
        end
      end else if (w_int_trig && r_int_n) begin
        r_int_arm <= 1'b1;
        r_int_cnt <= DLY_LD;
      end
    end
  end

  assign bus.miso        = r_miso;
  assign bus.int_n       = r_int_n;
  assign bus.load_ready  = w_ld_ready;
  assign bus.load_ovf    = r_ovf;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_ch      = r_cmd_ch;
  assign bus.cmd_len     = r_cmd_len;
  assign bus.cmd_trunc   = r_cmd_trunc;
  assign bus.cmd_rd_data = r_rx_buf[bus.cmd_rd_addr];
endmodule

// File: tb/tb_shtp_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_shtp_spi_responder
// Directed bench for shtp_spi_responder: packet framing and sequence numbers,
// INT timing, aborted-read resend, command capture, overflow, wake request
// and mid-transaction reset.
// ----------------------------------------------------------------------------
module tb_shtp_spi_responder;
  localparam int NUM_CH    = 6;
  localparam int TX_DEPTH  = 64;
  localparam int RX_DEPTH  = 32;
  localparam int INT_DELAY = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shtp_spi_responder_if #(.NUM_CH(NUM_CH), .RX_DEPTH(RX_DEPTH)) bus ();

  shtp_spi_responder #(
    .NUM_CH(NUM_CH), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .INT_DELAY(INT_DELAY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cv_cnt = 0;
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];

  always @(posedge clk) if (bus.cmd_valid === 1'b1) cv_cnt <= cv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host SPI mode-3 read/write of nbytes; MOSI bytes from mosi_q (0 beyond it).
  task automatic spi_xfer(input int nbytes);
    logic [7:0] v, m;
    miso_q.delete();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      m = (b < mosi_q.size()) ? mosi_q[b] : 8'h00;
      v = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        bus.sclk = 1'b0;
        bus.mosi = m[i];
        repeat (8) @(negedge clk);
        bus.sclk = 1'b1;
        v[i] = bus.miso;
        repeat (8) @(negedge clk);
      end
      miso_q.push_back(v);
    end
    repeat (8) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Pushes n payload bytes base, base+1, ... on channel ch; returns #load_ovf pulses.
  // Returns 1 time unit after the edge that accepted load_last.
  task automatic load_pkt(input int ch, input int n, input logic [7:0] base, output int ovf);
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_byte  = base + 8'(i);
      bus.load_last  = (i == n - 1);
      bus.load_ch    = 3'(ch);
      @(posedge clk);
      #1;
      if (bus.load_ovf === 1'b1) ovf++;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic wait_int(input string tag);
    int k;
    k = 0;
    while (bus.int_n !== 1'b0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(bus.int_n), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf, cv0;
    logic [7:0] acc;
    bus.cs_n = 1'b1; bus.sclk = 1'b1; bus.mosi = 1'b0; bus.ps0_wake_n = 1'b1;
    bus.load_valid = 1'b0; bus.load_byte = 8'h00; bus.load_last = 1'b0;
    bus.load_ch = 3'd0; bus.cmd_rd_addr = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);

    // Reset values
    chk("rst_miso",   32'(bus.miso), 32'd0);
    chk("rst_int_n",  32'(bus.int_n), 32'd1);
    chk("rst_ready",  32'(bus.load_ready), 32'd1);
    chk("rst_ovf",    32'(bus.load_ovf), 32'd0);
    chk("rst_cvalid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_cch",    32'(bus.cmd_ch), 32'd0);
    chk("rst_clen",   32'(bus.cmd_len), 32'd0);
    chk("rst_ctrunc", 32'(bus.cmd_trunc), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 14-byte packet on channel 3: INT exactly INT_DELAY cycles after load_last
    load_pkt(3, 14, 8'hA0, ovf);
    chk("p1_ovf", 32'(ovf), 32'd0);
    chk("p1_ready_low", 32'(bus.load_ready), 32'd0);
    repeat (INT_DELAY - 1) @(posedge clk);
    #1 chk("p1_int_early", 32'(bus.int_n), 32'd1);
    @(posedge clk);
    #1 chk("p1_int_low", 32'(bus.int_n), 32'd0);
    spi_xfer(18);
    chk("p1_len_lo", 32'(miso_q[0]), 32'h12);
    chk("p1_len_hi", 32'(miso_q[1]), 32'h00);
    chk("p1_ch",     32'(miso_q[2]), 32'h03);
    chk("p1_seq",    32'(miso_q[3]), 32'h00);
    for (int i = 0; i < 14; i++) chk($sformatf("p1_pay%0d", i), 32'(miso_q[4+i]), 32'hA0 + i);
    chk("p1_int_high", 32'(bus.int_n), 32'd1);
    chk("p1_ready_back", 32'(bus.load_ready), 32'd1);
    repeat (INT_DELAY + 10) @(negedge clk);
    chk("p1_int_stays_high", 32'(bus.int_n), 32'd1);

    // Second packet on ch 3 carries seq 1; ch 2 starts at seq 0
    load_pkt(3, 4, 8'h10, ovf);
    wait_int("p2_int");
    spi_xfer(8);
    chk("p2_len", 32'(miso_q[0]), 32'h08);
    chk("p2_seq", 32'(miso_q[3]), 32'h01);
    chk("p2_last", 32'(miso_q[7]), 32'h13);
    load_pkt(2, 2, 8'h55, ovf);
    wait_int("p3_int");
    spi_xfer(6);
    chk("p3_ch",  32'(miso_q[2]), 32'h02);
    chk("p3_seq", 32'(miso_q[3]), 32'h00);
    chk("p3_pay", 32'(miso_q[5]), 32'h56);

    // Aborted read: resend with same seq (2 on ch 3)
    load_pkt(3, 5, 8'hC0, ovf);
    wait_int("ab_int");
    spi_xfer(6);
    chk("ab_ready_low", 32'(bus.load_ready), 32'd0);
    chk("ab_int_high",  32'(bus.int_n), 32'd1);
    wait_int("ab_int_reassert");
    spi_xfer(9);
    chk("ab_len", 32'(miso_q[0]), 32'h09);
    chk("ab_seq", 32'(miso_q[3]), 32'h02);
    chk("ab_first", 32'(miso_q[4]), 32'hC0);
    chk("ab_last",  32'(miso_q[8]), 32'hC4);
    chk("ab_ready_back", 32'(bus.load_ready), 32'd1);

    // Host command capture
    cv0 = cv_cnt;
    mosi_q = '{8'h05, 8'h00, 8'h02, 8'h07, 8'hF9};
    spi_xfer(5);
    chk("cmd_pulses", 32'(cv_cnt - cv0), 32'd1);
    chk("cmd_ch",    32'(bus.cmd_ch), 32'h02);
    chk("cmd_len",   32'(bus.cmd_len), 32'd5);
    chk("cmd_trunc", 32'(bus.cmd_trunc), 32'd0);
    bus.cmd_rd_addr = 5'd4;
    #1 chk("cmd_rd4", 32'(bus.cmd_rd_data), 32'hF9);
    bus.cmd_rd_addr = 5'd3;
    #1 chk("cmd_rd3", 32'(bus.cmd_rd_data), 32'h07);
    mosi_q = '{8'h05, 8'h00, 8'h02, 8'h07};
    spi_xfer(4);
    chk("cmd2_pulses", 32'(cv_cnt - cv0), 32'd2);
    chk("cmd2_trunc",  32'(bus.cmd_trunc), 32'd1);
    chk("cmd2_len",    32'(bus.cmd_len), 32'd5);
    mosi_q.delete();

    // Overflow: TX_DEPTH payload bytes, last 4 dropped
    cv0 = cv_cnt;
    load_pkt(1, TX_DEPTH, 8'h00, ovf);
    chk("ovf_pulses", 32'(ovf), 32'd4);
    wait_int("ovf_int");
    spi_xfer(TX_DEPTH);
    chk("ovf_len_lo", 32'(miso_q[0]), 32'h40);
    chk("ovf_len_hi", 32'(miso_q[1]), 32'h00);
    chk("ovf_ch",     32'(miso_q[2]), 32'h01);
    chk("ovf_seq",    32'(miso_q[3]), 32'h00);
    chk("ovf_last",   32'(miso_q[TX_DEPTH-1]), 32'd59);
    chk("ovf_ready",  32'(bus.load_ready), 32'd1);

    // Wake with nothing pending: INT after the delay, all-zero read
    @(negedge clk);
    bus.ps0_wake_n = 1'b0;
    repeat (INT_DELAY - 1) @(posedge clk);
    #1 chk("wake_int_early", 32'(bus.int_n), 32'd1);
    repeat (4) @(posedge clk);
    #1 chk("wake_int_low", 32'(bus.int_n), 32'd0);
    bus.ps0_wake_n = 1'b1;
    spi_xfer(8);
    acc = 8'h00;
    foreach (miso_q[i]) acc = acc | miso_q[i];
    chk("wake_zero_pkt", 32'(acc), 32'd0);
    chk("wake_int_high", 32'(bus.int_n), 32'd1);

    // Reset during the 3rd byte of a read
    load_pkt(3, 4, 8'hE0, ovf);
    wait_int("rst_pkt_int");
    cv0 = cv_cnt;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus.sclk = 1'b0;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (8) @(negedge clk);
    end
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_miso",   32'(bus.miso), 32'd0);
    chk("mid_int_n",  32'(bus.int_n), 32'd1);
    chk("mid_ready",  32'(bus.load_ready), 32'd1);
    chk("mid_cvalid", 32'(bus.cmd_valid), 32'd0);
    chk("mid_clen",   32'(bus.cmd_len), 32'd0);
    repeat (2) @(negedge clk);
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (INT_DELAY + 20) @(negedge clk);
    chk("mid_no_cmd",   32'(cv_cnt - cv0), 32'd0);
    chk("mid_int_idle", 32'(bus.int_n), 32'd1);
    chk("mid_ready2",   32'(bus.load_ready), 32'd1);
    load_pkt(3, 2, 8'h77, ovf);
    wait_int("post_rst_int");
    spi_xfer(6);
    chk("post_rst_seq", 32'(miso_q[3]), 32'h00);
    chk("post_rst_pay", 32'(miso_q[4]), 32'h77);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
